// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: drives a stretched reset into the core, counts RUN cycles and
// retired instructions, and ends the run on halt, PC stall or cycle timeout.
// Optional feature macro: RUN_MONITOR_STALL_EN builds the PC-stall detector;
// without it pc is ignored and done_code never reports a stall.
module cpu_run_monitor #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned MAX_CYCLES  = 100,
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [PC_W-1:0]  pc,
    input  logic             retire,
    input  logic             halt_req,
    output logic             cpu_rst,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic             done,
    output logic [1:0]       done_code
);

    localparam int unsigned RCNT_W = $clog2(RST_CYCLES + 1);

    localparam logic [1:0] CODE_RUN     = 2'd0;
    localparam logic [1:0] CODE_TIMEOUT = 2'd1;
    localparam logic [1:0] CODE_HALT    = 2'd2;
    localparam logic [1:0] CODE_STALL   = 2'd3;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [RCNT_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   retire_q, retire_d;
    logic               done_q, done_d;
    logic [1:0]         code_q, code_d;

    logic [RCNT_W-1:0]  rst_cnt_inc_c;
    logic               rst_last_c;
    logic [CNT_W-1:0]   cycle_inc_c;
    logic [CNT_W-1:0]   retire_inc_c;
    logic               stall_hit_c;
    logic [1:0]         term_code_c;

`ifdef RUN_MONITOR_STALL_EN
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    logic [PC_W-1:0]    pc_prev_q, pc_prev_d;
    logic               pc_valid_q, pc_valid_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [STALL_W-1:0] stall_inc_c;

    // Stall run length: consecutive RUN edges with an unchanged, valid previous PC
    always_comb begin
        stall_inc_c = '0;
        if (pc_valid_q && (pc == pc_prev_q)) begin
            stall_inc_c = stall_q + STALL_W'(1);
        end
        stall_hit_c = (stall_inc_c == STALL_W'(STALL_LIMIT));
    end
`else
    logic unused_c;
    assign unused_c = ^{pc, 32'(STALL_LIMIT)};

    // Stall detection not built
    always_comb begin
        stall_hit_c = 1'b0;
    end
`endif

    // Post-increment counter values and the prioritised termination cause
    always_comb begin
        rst_cnt_inc_c = rst_cnt_q + RCNT_W'(1);
        rst_last_c    = (rst_cnt_inc_c == RCNT_W'(RST_CYCLES));
        cycle_inc_c   = cycle_q + CNT_W'(1);
        retire_inc_c  = retire_q;
        if (retire && (retire_q != {CNT_W{1'b1}})) begin
            retire_inc_c = retire_q + CNT_W'(1);
        end
        term_code_c = CODE_RUN;
        if (halt_req) begin
            term_code_c = CODE_HALT;
        end else if (stall_hit_c) begin
            term_code_c = CODE_STALL;
        end else if (cycle_inc_c == CNT_W'(MAX_CYCLES)) begin
            term_code_c = CODE_TIMEOUT;
        end
    end

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RESET;
            rst_cnt_q <= '0;
            cpu_rst_q <= 1'b1;
            cycle_q   <= '0;
            retire_q  <= '0;
            done_q    <= 1'b0;
            code_q    <= CODE_RUN;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cpu_rst_q <= cpu_rst_d;
            cycle_q   <= cycle_d;
            retire_q  <= retire_d;
            done_q    <= done_d;
            code_q    <= code_d;
        end
    end

`ifdef RUN_MONITOR_STALL_EN
    // Stall detector state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_prev_q  <= '0;
            pc_valid_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            pc_prev_q  <= pc_prev_d;
            pc_valid_q <= pc_valid_d;
            stall_q    <= stall_d;
        end
    end
`endif

    // Next state: restart always wins, then reset expiry or termination
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_RESET;
        end else begin
            unique case (state_q)
                ST_RESET: if (rst_last_c) state_d = ST_RUN;
                ST_RUN:   if (term_code_c != CODE_RUN) state_d = ST_DONE;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_RESET;
            endcase
        end
    end

    // Output and counter updates for the current state
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        cpu_rst_d = cpu_rst_q;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        done_d    = done_q;
        code_d    = code_q;
`ifdef RUN_MONITOR_STALL_EN
        pc_prev_d  = pc_prev_q;
        pc_valid_d = pc_valid_q;
        stall_d    = stall_q;
`endif
        if (restart) begin
            rst_cnt_d = '0;
            cpu_rst_d = 1'b1;
            cycle_d   = '0;
            retire_d  = '0;
            done_d    = 1'b0;
            code_d    = CODE_RUN;
`ifdef RUN_MONITOR_STALL_EN
            pc_valid_d = 1'b0;
            stall_d    = '0;
`endif
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    cpu_rst_d = 1'b1;
                    cycle_d   = '0;
                    retire_d  = '0;
                    done_d    = 1'b0;
                    code_d    = CODE_RUN;
                    if (rst_last_c) begin
                        rst_cnt_d = '0;
                        cpu_rst_d = 1'b0;
                    end else begin
                        rst_cnt_d = rst_cnt_inc_c;
                    end
                end
                ST_RUN: begin
                    cpu_rst_d = 1'b0;
                    cycle_d   = cycle_inc_c;
                    retire_d  = retire_inc_c;
`ifdef RUN_MONITOR_STALL_EN
                    pc_prev_d  = pc;
                    pc_valid_d = 1'b1;
                    stall_d    = stall_inc_c;
`endif
                    if (term_code_c != CODE_RUN) begin
                        done_d = 1'b1;
                        code_d = term_code_c;
                    end
                end
                ST_DONE: begin
                    cpu_rst_d = 1'b0;
                end
                default: begin
                    cpu_rst_d = 1'b1;
                end
            endcase
        end
    end

    assign cpu_rst      = cpu_rst_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
    assign done         = done_q;
    assign done_code    = code_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: two instances (32-bit/100-cycle and
// 4-bit/15-cycle) share stimulus; a run-level model predicts every output.
module tb_cpu_run_monitor;

    localparam int N = 2;
`ifdef RUN_MONITOR_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        restart;
    logic [31:0] pc;
    logic        retire;
    logic        halt_req;

    logic        a_cpu_rst, a_done;
    logic [31:0] a_cyc, a_ret;
    logic [1:0]  a_code;
    logic        b_cpu_rst, b_done;
    logic [3:0]  b_cyc, b_ret;
    logic [1:0]  b_code;

    int total;
    int bad;

    cpu_run_monitor #(.CNT_W(32), .PC_W(32), .RST_CYCLES(2), .MAX_CYCLES(100), .STALL_LIMIT(8)) dut_a (
        .clk(clk), .rst(rst), .restart(restart), .pc(pc), .retire(retire), .halt_req(halt_req),
        .cpu_rst(a_cpu_rst), .cycle_count(a_cyc), .retire_count(a_ret), .done(a_done), .done_code(a_code)
    );

    cpu_run_monitor #(.CNT_W(4), .PC_W(32), .RST_CYCLES(2), .MAX_CYCLES(15), .STALL_LIMIT(8)) dut_b (
        .clk(clk), .rst(rst), .restart(restart), .pc(pc), .retire(retire), .halt_req(halt_req),
        .cpu_rst(b_cpu_rst), .cycle_count(b_cyc), .retire_count(b_ret), .done(b_done), .done_code(b_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- run-level model ----------------
    bit          m_in_reset;
    int          m_rst_edges;
    bit          m_cpu_rst;
    longint      m_cyc [N];
    longint      m_ret [N];
    bit          m_done[N];
    int          m_code[N];
    logic [31:0] m_hist[$];

    function automatic longint max_of(int i);
        return (i == 0) ? 64'd100 : 64'd15;
    endfunction

    function automatic longint sat_of(int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'd15;
    endfunction

    // Number of trailing RUN samples equal to the sample before them
    function automatic int trailing_repeats();
        int n = 0;
        for (int k = m_hist.size() - 1; k > 0; k--) begin
            if (m_hist[k] != m_hist[k-1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_in_reset  = 1'b1;
        m_rst_edges = 0;
        m_cpu_rst   = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_cyc[i] = 0; m_ret[i] = 0; m_done[i] = 1'b0; m_code[i] = 0;
        end
        m_hist.delete();
    endtask

    task automatic model_edge();
        int reps;
        if (rst || restart) begin
            model_reset();
        end else if (m_in_reset) begin
            m_rst_edges++;
            if (m_rst_edges == 2) begin
                m_in_reset = 1'b0;
                m_cpu_rst  = 1'b0;
            end
        end else begin
            m_hist.push_back(pc);
            reps = trailing_repeats();
            for (int i = 0; i < N; i++) begin
                if (!m_done[i]) begin
                    m_cyc[i]++;
                    if (retire && m_ret[i] < sat_of(i)) m_ret[i]++;
                    if (halt_req)                    m_code[i] = 2;
                    else if (STALL_EN && reps >= 8)  m_code[i] = 3;
                    else if (m_cyc[i] == max_of(i))  m_code[i] = 1;
                    if (m_code[i] != 0) m_done[i] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a_cpu_rst", a_cpu_rst, m_cpu_rst);
        chk("a_cycle",   a_cyc,     m_cyc[0]);
        chk("a_retire",  a_ret,     m_ret[0]);
        chk("a_done",    a_done,    m_done[0]);
        chk("a_code",    a_code,    m_code[0]);
        chk("b_cpu_rst", b_cpu_rst, m_cpu_rst);
        chk("b_cycle",   b_cyc,     m_cyc[1]);
        chk("b_retire",  b_ret,     m_ret[1]);
        chk("b_done",    b_done,    m_done[1]);
        chk("b_code",    b_code,    m_code[1]);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_ticks(input int n, input bit inc_pc);
        for (int k = 0; k < n; k++) begin
            tick();
            if (inc_pc) pc = pc + 32'd4;
        end
    endtask

    task automatic run_until_done(input int budget, input bit inc_pc);
        int k = 0;
        while (!a_done && k < budget) begin
            tick();
            if (inc_pc) pc = pc + 32'd4;
            k++;
        end
        if (!a_done) chk("done_within_budget", a_done, 1);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        run_ticks(2, 1'b0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b0; restart = 1'b0; retire = 1'b0; halt_req = 1'b0; pc = 32'd0;
        #1 rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_all();
        chk("lit_reset_cpu_rst", a_cpu_rst, 1);
        chk("lit_reset_cycle", a_cyc, 0);
        rst = 1'b0;

        // Reset sequence
        tick();
        chk("lit_rstseq_edge1_cpu_rst", a_cpu_rst, 1);
        tick();
        chk("lit_rstseq_edge2_cpu_rst", a_cpu_rst, 0);
        chk("lit_rstseq_edge2_cycle", a_cyc, 0);

        // Timeout with incrementing PC and constant retire
        pc = 32'd0; retire = 1'b1;
        tick();
        pc = pc + 32'd4;
        chk("lit_first_run_cycle", a_cyc, 1);
        run_until_done(200, 1'b1);
        chk("lit_timeout_code", a_code, 1);
        chk("lit_timeout_cycle", a_cyc, 100);
        chk("lit_timeout_retire", a_ret, 100);
        chk("lit_sat_b_retire", b_ret, 15);
        chk("lit_sat_b_code", b_code, 1);
        halt_req = 1'b1;
        run_ticks(10, 1'b1);
        halt_req = 1'b0;
        chk("lit_frozen_cycle", a_cyc, 100);
        chk("lit_frozen_retire", a_ret, 100);
        chk("lit_frozen_code", a_code, 1);

        // Restart from DONE and identical repeat
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("lit_restart_done", a_done, 0);
        chk("lit_restart_cycle", a_cyc, 0);
        chk("lit_restart_cpu_rst", a_cpu_rst, 1);
        run_ticks(2, 1'b0);
        pc = 32'd0;
        run_until_done(200, 1'b1);
        chk("lit_repeat_cycle", a_cyc, 100);
        chk("lit_repeat_code", a_code, 1);

        // Halt on RUN cycle 37
        do_restart();
        pc = 32'd0;
        run_ticks(36, 1'b1);
        chk("lit_pre_halt_done", a_done, 0);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("lit_halt_code", a_code, 2);
        chk("lit_halt_cycle", a_cyc, 37);
        chk("lit_halt_retire", a_ret, 37);

        // Halt coinciding with timeout
        do_restart();
        run_ticks(99, 1'b1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("lit_halt_timeout_code", a_code, 2);
        chk("lit_halt_timeout_cycle", a_cyc, 100);

        // Restart beats a same-cycle halt
        do_restart();
        run_ticks(10, 1'b1);
        halt_req = 1'b1; restart = 1'b1;
        tick();
        halt_req = 1'b0; restart = 1'b0;
        chk("lit_restart_prio_done", a_done, 0);
        chk("lit_restart_prio_code", a_code, 0);

        // Restart during RESET restarts the reset count
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        tick();
        chk("lit_rst_restart_cpu_rst", a_cpu_rst, 1);
        tick();
        chk("lit_rst_restart_release", a_cpu_rst, 0);

        // Constant PC
        do_restart();
        pc = 32'h40; retire = 1'b0;
        run_until_done(200, 1'b0);
        chk("lit_stall_code", a_code, STALL_EN ? 3 : 1);
        chk("lit_stall_cycle", a_cyc, STALL_EN ? 9 : 100);
        chk("lit_stall_retire", a_ret, 0);

        // Asynchronous reset mid-run
        retire = 1'b1;
        do_restart();
        pc = 32'd0;
        run_ticks(50, 1'b1);
        chk("lit_pre_async_cycle", a_cyc, 50);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("lit_async_cpu_rst", a_cpu_rst, 1);
        chk("lit_async_cycle", a_cyc, 0);
        chk("lit_async_retire", a_ret, 0);
        tick();
        rst = 1'b0;
        run_ticks(2, 1'b0);
        tick();
        chk("lit_after_async_cycle", a_cyc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run-control and termination monitor for CPU simulation and bring-up. Drives a configurable-length reset into the core, counts cycles and retired instructions, and flags end of run on halt request, PC stall, or cycle timeout, recording the cause. Sits between the top-level clock/reset and the `cpu` instance. Benches poll `done` instead of hard-coding a cycle count.

## Interface
Parameters:
- `CNT_W`, 32: width of the cycle and retire counters.
- `PC_W`, 32: width of the `pc` input.
- `RST_CYCLES`, 2: cycles `cpu_rst` is held after entering RESET; ≥1.
- `MAX_CYCLES`, 100: RUN cycles before timeout; 1 ≤ value ≤ 2^CNT_W−1.
- `STALL_LIMIT`, 8: consecutive unchanged-PC cycles that end the run; ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `restart`  in  1  synchronous request to re-enter RESET.
- `pc`  in  PC_W  current core PC.
- `retire`  in  1  one-cycle strobe per retired instruction.
- `halt_req`  in  1  core halt (ebreak/ecall) indication.
- `cpu_rst`  out  1  reset to the core; registered.
- `cycle_count`  out  CNT_W  RUN cycles elapsed.
- `retire_count`  out  CNT_W  instructions retired in RUN.
- `done`  out  1  run finished; level.
- `done_code`  out  2  0 running, 1 timeout, 2 halt, 3 stall.

## Operation
- States: RESET, RUN, DONE.
- On `rst`: state RESET with reset counter 0. Outputs: `cpu_rst`=1, `cycle_count`=0, `retire_count`=0, `done`=0, `done_code`=0. Stall counter 0, PC-valid flag 0.
- RESET:
  - `cpu_rst`=1 and the reset counter increments.
  - After RST_CYCLES edges in RESET, go to RUN and drive `cpu_rst`=0.
  - Counters are cleared on entry.
- RUN, evaluated every edge:
  - `cycle_count` +1.
  - `retire_count` +1 if `retire`; saturates at all-ones.
  - `pc` is registered into `pc_prev` and the PC-valid flag is set.
  - If PC-valid and `pc`==`pc_prev`, the stall counter +1; otherwise it clears to 0.
- Termination check uses the post-increment values. Priority: halt > stall > timeout.
  - `halt_req`=1 gives code 2.
  - Stall counter reaching STALL_LIMIT gives code 3.
  - `cycle_count` reaching MAX_CYCLES gives code 1.
  - On any termination, the state goes to DONE, `done`=1, and `done_code` is set on the same edge. The terminating cycle's `retire` is counted.
- DONE:
  - Counters frozen, `cpu_rst`=0, `done` held.
  - Later `halt_req`, `retire`, and `pc` activity are ignored.
- `restart`=1 in RUN or DONE goes to RESET on the next edge and clears `done`, `done_code`, counters, the stall counter and PC-valid. `restart` in RESET restarts the reset counter.
- `restart` has priority over any termination in the same cycle.

## Timing
- First RUN edge sets `cycle_count`=1.
- Timeout asserts `done` on the edge where `cycle_count` becomes MAX_CYCLES.
- Halt latency: 1 edge from `halt_req` sampled high to `done`=1.
- Stall with constant `pc` from the first RUN cycle:
  - The first RUN cycle only primes `pc_prev`.
  - `done` asserts on RUN edge STALL_LIMIT+1.
- `rst` asserted mid-run acts immediately, without waiting for a clock edge, and returns all outputs to their reset values.

## Configuration
- `RUN_MONITOR_STALL_EN` defined: stall detection is built as described.
- Not defined:
  - No stall counter, `pc_prev` or PC-valid logic.
  - `pc` is ignored and `done_code` never equals 3.
  - Only halt and timeout terminate the run.

## Test plan
- Reset sequence: RST_CYCLES=2, `rst` pulsed → `cpu_rst`=1 for 2 edges after `rst` falls, then 0; `cycle_count`=0 until the first RUN edge.
- Timeout: MAX_CYCLES=100, `pc` incrementing by 4, `retire` always 1 → `done`=1 and `done_code`=1 with `cycle_count`=100 and `retire_count`=100; both frozen 10 cycles later.
- Halt: `halt_req` pulsed on RUN cycle 37 → `done_code`=2, `cycle_count`=37. Halt together with timeout on cycle 100 → code 2.
- Stall (macro defined): STALL_LIMIT=8, `pc` held at 0x40 from RUN cycle 1 → `done_code`=3 at `cycle_count`=9. Macro undefined, same stimulus → `done_code`=1 at 100.
- Restart and async reset: `restart` on DONE → RESET, `done`=0 and counters 0; the run repeats identically. `rst` asserted at RUN cycle 50 between edges → `cpu_rst`=1 and counters 0 before the next edge.
- Saturation: CNT_W=4, MAX_CYCLES=15, `retire`=1 → `retire_count`=15 with no wrap, `done_code`=1.
